// File: rtl/ucie_ctl_tx_top_if.sv
// -----------------------------------------------------------------------------
// ucie_ctl_tx_top_if
//   Bundles the FDI (adapter-facing) and RDI (physical-layer-facing) handshake
//   signals of the UCIe controller transmit block.
//
//   Signals:
//     i_fdi_lp_data   adapter -> block  transmit word
//     i_fdi_lp_valid  adapter -> block  word valid this cycle
//     o_fdi_pl_trdy   block -> adapter  word accepted this cycle
//     i_rdi_pl_trdy   PHY -> block      PHY accepts RDI word this cycle
//     o_rdi_lp_data   block -> PHY      buffer head word
//     o_rdi_lp_valid  block -> PHY      head word valid
//     o_rdi_lp_parity block -> PHY      XOR of o_rdi_lp_data, only when
//                                       UCIE_CTL_TX_PARITY_EN is defined
//
//   Modports:
//     master  the transmit block itself
//     slave   the surrounding adapter / PHY
// -----------------------------------------------------------------------------
interface ucie_ctl_tx_top_if #(
  parameter int NBYTES = 8
);
  logic [NBYTES-1:0] i_fdi_lp_data;
  logic              i_fdi_lp_valid;
  logic              o_fdi_pl_trdy;
  logic              i_rdi_pl_trdy;
  logic [NBYTES-1:0] o_rdi_lp_data;
  logic              o_rdi_lp_valid;
`ifdef UCIE_CTL_TX_PARITY_EN
  logic              o_rdi_lp_parity;
`endif

  modport master (
`ifdef UCIE_CTL_TX_PARITY_EN
    output o_rdi_lp_parity,
`endif
    input  i_fdi_lp_data,
    input  i_fdi_lp_valid,
    output o_fdi_pl_trdy,
    input  i_rdi_pl_trdy,
    output o_rdi_lp_data,
    output o_rdi_lp_valid
  );

  modport slave (
`ifdef UCIE_CTL_TX_PARITY_EN
    input  o_rdi_lp_parity,
`endif
    output i_fdi_lp_data,
    output i_fdi_lp_valid,
    input  o_fdi_pl_trdy,
    output i_rdi_pl_trdy,
    input  o_rdi_lp_data,
    input  o_rdi_lp_valid
  );
endinterface

// File: rtl/ucie_ctl_tx_top.sv
// -----------------------------------------------------------------------------
// ucie_ctl_tx_top
//   UCIe controller transmit path: an IDLE/ACTIVE/DRAIN link-state FSM in
//   front of a DEPTH-entry FIFO that carries words from the FDI side to the
//   RDI side. New words are accepted only in ACTIVE; buffered words keep
//   flowing out in ACTIVE and DRAIN. Words offered outside ACTIVE raise a
//   sticky drop flag, cleared when the link goes IDLE -> ACTIVE.
//
//   Ports:
//     i_clk            clock, all state on the rising edge
//     i_rst            asynchronous reset, active low
//     i_state_request  1 = request ACTIVE, 0 = request IDLE
//     bus              FDI/RDI handshake interface (master modport)
//     o_tx_active      FSM is in ACTIVE (registered)
//     o_drop_detected  sticky: FDI data offered while in IDLE or DRAIN
//
//   Parameters:
//     NBYTES  data bus width in bits
//     DEPTH   FIFO entries, power of two, >= 2
//
//   Optional feature:
//     UCIE_CTL_TX_PARITY_EN  adds bus.o_rdi_lp_parity = XOR of the RDI data
//                            word, forced to 0 when the word is not valid.
// -----------------------------------------------------------------------------
module ucie_ctl_tx_top #(
  parameter int NBYTES = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_state_request,
  ucie_ctl_tx_top_if.master       bus,
  output logic                    o_tx_active,
  output logic                    o_drop_detected
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e            state_q;
  logic              tx_active_q;
  logic              drop_q;

  logic [NBYTES-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Acceptance looks only at registered occupancy: a pop while full frees the
  // slot for the following cycle, never the same one.
  assign bus.o_fdi_pl_trdy  = (state_q == ST_ACTIVE) && !full;
  assign bus.o_rdi_lp_valid = !empty && (state_q != ST_IDLE);
  assign bus.o_rdi_lp_data  = mem_q[rd_ptr_q[AW-1:0]];

  assign push = bus.i_fdi_lp_valid && bus.o_fdi_pl_trdy;
  assign pop  = bus.o_rdi_lp_valid && bus.i_rdi_pl_trdy;

  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

`ifdef UCIE_CTL_TX_PARITY_EN
  assign bus.o_rdi_lp_parity = bus.o_rdi_lp_valid && (^bus.o_rdi_lp_data);
`endif

  assign o_tx_active     = tx_active_q;
  assign o_drop_detected = drop_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; its content is only observable
  // through o_rdi_lp_data while valid, and the reset pointers mark it empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.i_fdi_lp_data;
    end
  end

  // Link-state FSM with registered o_tx_active and sticky drop flag. On an
  // IDLE -> ACTIVE edge the clear wins over a simultaneous drop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      tx_active_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_state_request) begin
            state_q     <= ST_ACTIVE;
            tx_active_q <= 1'b1;
            drop_q      <= 1'b0;
          end else if (bus.i_fdi_lp_valid) begin
            drop_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!i_state_request) begin
            state_q     <= ST_DRAIN;
            tx_active_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (bus.i_fdi_lp_valid) begin
            drop_q <= 1'b1;
          end
          if (i_state_request) begin
            state_q     <= ST_ACTIVE;
            tx_active_q <= 1'b1;
          end else if (empty) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          tx_active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_tx_top.sv
// -----------------------------------------------------------------------------
// tb_ucie_ctl_tx_top
//   Self-checking bench for ucie_ctl_tx_top. A queue-based reference model
//   tracks link state, buffered words and the drop flag; every cycle the DUT
//   outputs are compared against it. Directed scenarios add literal
//   expectations, then a randomized phase exercises the handshakes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ucie_ctl_tx_top;

  localparam int NB    = 8;
  localparam int DEPTH = 4;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DRAIN  = 2;

  logic clk;
  logic rst_n;
  logic state_request;
  logic tx_active;
  logic drop_detected;

  ucie_ctl_tx_top_if #(.NBYTES(NB)) bus ();

  ucie_ctl_tx_top #(.NBYTES(NB), .DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_state_request (state_request),
    .bus             (bus),
    .o_tx_active     (tx_active),
    .o_drop_detected (drop_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           m_state;
  bit           m_drop;
  logic [NB-1:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_drop  = 1'b0;
    m_q.delete();
  endtask

  // Compare every DUT output against the model's current state.
  task automatic compare_model();
    bit exp_valid;
    exp_valid = (m_q.size() > 0) && (m_state != M_IDLE);
    check("m_trdy", 32'(bus.o_fdi_pl_trdy), 32'((m_state == M_ACTIVE) && (m_q.size() < DEPTH)));
    check("m_valid", 32'(bus.o_rdi_lp_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(bus.o_rdi_lp_data), 32'(m_q[0]));
    check("m_active", 32'(tx_active), 32'(m_state == M_ACTIVE));
    check("m_drop", 32'(drop_detected), 32'(m_drop));
`ifdef UCIE_CTL_TX_PARITY_EN
    check("m_parity", 32'(bus.o_rdi_lp_parity), exp_valid ? 32'(^m_q[0]) : 32'd0);
`endif
  endtask

  // Advance the model by one rising edge with the current inputs.
  task automatic model_step();
    bit do_push, do_pop;
    do_push = (m_state == M_ACTIVE) && (m_q.size() < DEPTH) && bus.i_fdi_lp_valid;
    do_pop  = (m_q.size() > 0) && (m_state != M_IDLE) && bus.i_rdi_pl_trdy;
    if (m_state != M_ACTIVE && bus.i_fdi_lp_valid) m_drop = 1'b1;
    case (m_state)
      M_IDLE:   if (state_request) begin m_state = M_ACTIVE; m_drop = 1'b0; end
      M_ACTIVE: if (!state_request) m_state = M_DRAIN;
      default: begin
        if (state_request) m_state = M_ACTIVE;
        else if (m_q.size() == 0) m_state = M_IDLE;
      end
    endcase
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(bus.i_fdi_lp_data);
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model, pass edge.
  task automatic step(input bit req, input bit v, input logic [NB-1:0] d, input bit rtrdy);
    state_request      = req;
    bus.i_fdi_lp_valid = v;
    bus.i_fdi_lp_data  = d;
    bus.i_rdi_pl_trdy  = rtrdy;
    @(negedge clk);
    compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    state_request      = 1'b0;
    bus.i_fdi_lp_valid = 1'b0;
    bus.i_fdi_lp_data  = '0;
    bus.i_rdi_pl_trdy  = 1'b0;
    model_reset();

    #12;
    check("rst_valid", 32'(bus.o_rdi_lp_valid), 32'd0);
    check("rst_trdy", 32'(bus.o_fdi_pl_trdy), 32'd0);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_drop", 32'(drop_detected), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ordered transfer with one-cycle latency.
    step(1, 0, 8'h00, 1);
    check("act_entry", 32'(tx_active), 32'd1);
    step(1, 1, 8'h11, 1);
    check("lat_v1", 32'(bus.o_rdi_lp_valid), 32'd1);
    check("lat_d1", 32'(bus.o_rdi_lp_data), 32'h11);
    step(1, 1, 8'h22, 1);
    check("lat_d2", 32'(bus.o_rdi_lp_data), 32'h22);
    step(1, 1, 8'h33, 1);
    check("lat_d3", 32'(bus.o_rdi_lp_data), 32'h33);
    step(1, 0, 8'h00, 1);
    check("lat_empty", 32'(bus.o_rdi_lp_valid), 32'd0);

    // Backpressure: five offered, four accepted, no drop, head held.
    for (int i = 0; i < 5; i++) step(1, 1, 8'hA0 + 8'(i), 0);
    check("full_trdy", 32'(bus.o_fdi_pl_trdy), 32'd0);
    check("full_drop", 32'(drop_detected), 32'd0);
    check("full_head", 32'(bus.o_rdi_lp_data), 32'hA0);
    // Pop while full: trdy rises only the cycle after.
    step(1, 1, 8'hA4, 1);
    check("full_pop_trdy", 32'(bus.o_fdi_pl_trdy), 32'd1);
    check("full_pop_head", 32'(bus.o_rdi_lp_data), 32'hA1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1);

    // Drain: three buffered words leave after request drops.
    for (int i = 0; i < 3; i++) step(1, 1, 8'hC0 + 8'(i), 0);
    step(0, 0, 8'h00, 0);
    check("drain_trdy", 32'(bus.o_fdi_pl_trdy), 32'd0);
    check("drain_active", 32'(tx_active), 32'd0);
    check("drain_valid", 32'(bus.o_rdi_lp_valid), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    check("drain_idle_valid", 32'(bus.o_rdi_lp_valid), 32'd0);

    // Drop in IDLE, cleared on entry to ACTIVE.
    step(0, 1, 8'h55, 0);
    check("drop_set", 32'(drop_detected), 32'd1);
    step(0, 0, 8'h00, 0);
    check("drop_sticky", 32'(drop_detected), 32'd1);
    step(1, 0, 8'h00, 0);
    check("drop_clear", 32'(drop_detected), 32'd0);

    // Parity pin values: 0x03 -> 0, 0x07 -> 1.
    step(1, 1, 8'h03, 0);
`ifdef UCIE_CTL_TX_PARITY_EN
    check("par_03", 32'(bus.o_rdi_lp_parity), 32'd0);
`endif
    step(1, 1, 8'h07, 1);
`ifdef UCIE_CTL_TX_PARITY_EN
    check("par_07", 32'(bus.o_rdi_lp_parity), 32'd1);
`endif
    check("par_head", 32'(bus.o_rdi_lp_data), 32'h07);

    // Reset mid-stream with two words buffered.
    step(1, 1, 8'hE1, 0);
    state_request      = 1'b0;
    bus.i_fdi_lp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.o_rdi_lp_valid), 32'd0);
    check("mrst_active", 32'(tx_active), 32'd0);
    check("mrst_trdy", 32'(bus.o_fdi_pl_trdy), 32'd0);
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 8'h00, 1);
    check("mrst_empty", 32'(bus.o_rdi_lp_valid), 32'd0);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
           NB'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
